banner_column_reader: RTL and testbench

- Reader for the synchronous banner ROMs (registered address, 57-bit word per address, one word = one banner column).
- Sweeps a WIN-column window of the banner and streams one column per valid/ready handshake to the LED-matrix display driver.
- Compensates for the ROM's one-cycle address registration.
- Advances the window by one column every SCROLL_DIV frames so the banner scrolls, wrapping at the banner end.

---
 rtl/banner_column_reader.sv | 114 +++++++++++
 tb/tb_banner_column_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/banner_column_reader.sv
// banner_column_reader: streams a scrolling WIN-column window of a registered-address banner ROM, one column per valid/ready handshake
module banner_column_reader #(
    parameter int NCOLS      = 129,
    parameter int WIN        = 16,
    parameter int HEIGHT     = 57,
    parameter int AW         = 8,
    parameter int SCROLL_DIV = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    output logic [AW-1:0]                         rom_addr,
    input  logic [HEIGHT-1:0]                     rom_data,
    output logic [HEIGHT-1:0]                     col_data,
    output logic                                  col_valid,
    input  logic                                  col_ready,
    output logic [(WIN > 1 ? $clog2(WIN) : 1)-1:0] col_idx,
    output logic                                  frame_last,
    output logic [AW-1:0]                         scroll_pos
);
    localparam int IW = WIN > 1 ? $clog2(WIN) : 1;
    localparam int FW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
    localparam logic [IW-1:0] LAST_COL = IW'(WIN - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(SCROLL_DIV - 1);
    localparam logic [AW-1:0] LAST_OFF = AW'(NCOLS - 1);
    localparam logic [AW:0] NC = (AW + 1)'(NCOLS);

    typedef enum logic [1:0] {IDLE, ISSUE, FETCH, SEND} state_t;

    state_t state, state_n;
    logic [AW-1:0] rom_addr_n, offset, offset_n, step_off;
    logic [HEIGHT-1:0] col_data_n;
    logic col_valid_n, frame_last_n;
    logic [IW-1:0] col_idx_n;
    logic [FW-1:0] frame_cnt, frame_cnt_n;

    // window offset plus column, wrapped once at the banner end
    function automatic logic [AW-1:0] addr(input logic [AW-1:0] o, input logic [IW-1:0] c);
        logic [AW:0] s;
        s = {1'b0, o} + (AW + 1)'(c);
        return s < NC ? AW'(s) : AW'(s - NC);
    endfunction

    assign scroll_pos = offset;
    assign step_off = frame_cnt == LAST_FRAME ? (offset == LAST_OFF ? '0 : offset + 1'b1) : offset;

    // state and all registered outputs; reset returns everything to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rom_addr   <= '0;
            col_data   <= '0;
            col_valid  <= 1'b0;
            col_idx    <= '0;
            frame_last <= 1'b0;
            offset     <= '0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            rom_addr   <= rom_addr_n;
            col_data   <= col_data_n;
            col_valid  <= col_valid_n;
            col_idx    <= col_idx_n;
            frame_last <= frame_last_n;
            offset     <= offset_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

    // next state; ISSUE covers the ROM's address register, FETCH captures its data
    always_comb begin
        state_n      = state;
        rom_addr_n   = rom_addr;
        col_data_n   = col_data;
        col_valid_n  = col_valid;
        col_idx_n    = col_idx;
        frame_last_n = frame_last;
        offset_n     = offset;
        frame_cnt_n  = frame_cnt;
        case (state)
            IDLE: if (en) begin
                rom_addr_n = addr(offset, '0);
                col_idx_n  = '0;
                state_n    = ISSUE;
            end
            ISSUE: state_n = FETCH;
            FETCH: begin
                col_data_n   = rom_data;
                col_valid_n  = 1'b1;
                frame_last_n = col_idx == LAST_COL;
                state_n      = SEND;
            end
            default: if (col_ready) begin
                col_valid_n  = 1'b0;
                frame_last_n = 1'b0;
                if (col_idx != LAST_COL) begin
                    col_idx_n  = col_idx + 1'b1;
                    rom_addr_n = addr(offset, col_idx + 1'b1);
                    state_n    = ISSUE;
                end else begin
                    frame_cnt_n = frame_cnt == LAST_FRAME ? '0 : frame_cnt + 1'b1;
                    offset_n    = step_off;
                    if (en) begin
                        rom_addr_n = step_off;
                        col_idx_n  = '0;
                        state_n    = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_banner_column_reader.sv
// tb_banner_column_reader: checks the banner reader against a frame/scroll arithmetic model of the column stream
module tb_banner_column_reader;
    localparam int NCOLS = 129, WIN = 16, HEIGHT = 57, AW = 8, SD = 4, IW = $clog2(WIN);

    logic clk = 0, rst_n = 0, en = 0, col_ready = 0;
    logic [AW-1:0] rom_addr, scroll_pos;
    logic [HEIGHT-1:0] rom_data = '0, col_data, saved;
    logic col_valid, frame_last;
    logic [IW-1:0] col_idx;
    logic [HEIGHT-1:0] rom_mem [NCOLS];
    int errors = 0, checks = 0, n = 0, n0;
    int mf, mc, moff, ma;
    bit seen128, seen0;

    typedef struct {
        logic v;
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
    } row_t;
    row_t tbl [7];

    always #5 clk = ~clk;

    banner_column_reader dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
        .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
        .col_idx(col_idx), .frame_last(frame_last), .scroll_pos(scroll_pos)
    );

    // synchronous ROM: registers the address, data appears the following cycle
    always @(posedge clk) rom_data <= (rom_addr < NCOLS) ? rom_mem[rom_addr] : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard: handshake number n belongs to frame n/WIN, column n%WIN
    always @(negedge clk) begin
        if (!rst_n) n = 0;
        else if (col_valid && col_ready) begin
            mf = n / WIN;
            mc = n % WIN;
            moff = (mf / SD) % NCOLS;
            ma = (moff + mc) % NCOLS;
            check("sb_col_data", 64'(col_data), 64'(rom_mem[ma]));
            check("sb_col_idx", 64'(col_idx), 64'(mc));
            check("sb_frame_last", 64'(frame_last), 64'(mc == WIN - 1));
            check("sb_rom_addr", 64'(rom_addr), 64'(ma));
            check("sb_scroll_pos", 64'(scroll_pos), 64'(moff));
            n++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input int idx, input string name);
        for (int t = 0; t < 300 && !(col_valid && col_idx == IW'(idx)); t++) cyc();
        check(name, 64'(col_valid && col_idx == IW'(idx)), 64'(1));
    endtask

    task automatic wait_n(input int target, input string name);
        for (int t = 0; t < 3000 && n < target; t++) cyc();
        check(name, 64'(n >= target), 64'(1));
    endtask

    task automatic restart();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < NCOLS; i++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            rom_mem[i] = r[HEIGHT-1:0];
        end
        rom_mem[0] = 57'h7;
        tbl = '{'{1'b0, 4'd0, 8'd0}, '{1'b0, 4'd0, 8'd0}, '{1'b1, 4'd0, 8'd0},
                '{1'b0, 4'd1, 8'd1}, '{1'b0, 4'd1, 8'd1}, '{1'b1, 4'd1, 8'd1},
                '{1'b0, 4'd2, 8'd2}};

        // reset held with en high
        en = 1;
        col_ready = 1;
        repeat (3) cyc();
        check("rst_rom_addr", 64'(rom_addr), 0);
        check("rst_col_valid", 64'(col_valid), 0);
        check("rst_scroll_pos", 64'(scroll_pos), 0);
        check("rst_col_idx", 64'(col_idx), 0);
        check("rst_frame_last", 64'(frame_last), 0);
        check("rst_col_data", 64'(col_data), 0);

        // cycle-exact start-up and 3-cycle column period
        rst_n = 1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            check($sformatf("tbl%0d_valid", k + 1), 64'(col_valid), 64'(tbl[k].v));
            check($sformatf("tbl%0d_idx", k + 1), 64'(col_idx), 64'(tbl[k].idx));
            check($sformatf("tbl%0d_addr", k + 1), 64'(rom_addr), 64'(tbl[k].addr));
            if (tbl[k].v) check($sformatf("tbl%0d_data", k + 1), 64'(col_data), 64'(rom_mem[tbl[k].addr]));
        end

        // full first frame, then next frame starts at the unchanged offset
        wait_n(16, "frame1_done");
        check("frame1_count", 64'(n), 16);
        check("frame1_scroll", 64'(scroll_pos), 0);
        check("frame2_addr0", 64'(rom_addr), 0);

        // backpressure on column 5
        restart();
        wait_col(5, "bp_reach5");
        col_ready = 0;
        saved = col_data;
        n0 = n;
        repeat (10) begin
            cyc();
            check("bp_data", 64'(col_data), 64'(saved));
            check("bp_idx", 64'(col_idx), 5);
            check("bp_valid", 64'(col_valid), 1);
            check("bp_addr", 64'(rom_addr), 5);
        end
        check("bp_no_hs", 64'(n), 64'(n0));
        col_ready = 1;
        cyc();
        check("bp_next_addr", 64'(rom_addr), 6);
        check("bp_valid_drop", 64'(col_valid), 0);

        // four frames advance the window by one column
        wait_n(64, "scroll_4frames");
        check("scroll_pos1", 64'(scroll_pos), 1);
        check("scroll_addr1", 64'(rom_addr), 1);

        // en dropped mid-frame: frame completes, then idle
        restart();
        wait_col(3, "en_reach3");
        en = 0;
        wait_n(16, "en_frame_done");
        repeat (20) cyc();
        check("en_count", 64'(n), 16);
        check("en_idle_valid", 64'(col_valid), 0);
        check("en_idle_addr", 64'(rom_addr), 15);
        en = 1;
        wait_col(0, "en_resume");
        check("en_resume_addr", 64'(rom_addr), 0);

        // async reset during SEND after the window has scrolled
        wait_n(70, "rst_prep");
        check("rst_prep_scroll", 64'(scroll_pos), 1);
        wait_col(9, "rst_reach9");
        col_ready = 0;
        rst_n = 0;
        #1;
        check("arst_valid", 64'(col_valid), 0);
        check("arst_scroll", 64'(scroll_pos), 0);
        check("arst_addr", 64'(rom_addr), 0);
        repeat (2) cyc();
        rst_n = 1;
        col_ready = 1;
        wait_col(0, "arst_restart");
        check("arst_restart_addr", 64'(rom_addr), 0);
        check("arst_restart_scroll", 64'(scroll_pos), 0);

        // long random run through the full banner wrap
        restart();
        for (int t = 0; t < 70000 && n < 8256 + 32; t++) begin
            en = $urandom_range(0, 15) != 0;
            col_ready = $urandom_range(0, 3) != 0;
            cyc();
            if (n == 8192 && !seen128) begin
                seen128 = 1;
                check("wrap_scroll128", 64'(scroll_pos), 128);
            end
            if (n == 8256 && !seen0) begin
                seen0 = 1;
                check("wrap_scroll0", 64'(scroll_pos), 0);
            end
        end
        check("wrap_reached", 64'(seen128 && seen0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
